// File: rtl/paralelo_serial.sv
// Serial link transmitter: 8-bit parallel in, MSB-first bit stream out.
// Optional PERIODIC_COMMA_EN forces a comma every SKIP_PERIOD data bytes.
module paralelo_serial #(
  parameter int COMMA_COUNT = 4,
  parameter int SKIP_PERIOD = 16
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       valid_out,
  output logic       active_out
);

  typedef enum logic {SYNC, SEND} state_t;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam logic [3:0] LAST_COMMA = 4'(COMMA_COUNT - 1);

  state_t      state, state_nx;
  logic [7:0]  shreg, shreg_nx;
  logic [2:0]  bit_cnt;
  logic [3:0]  comma_cnt, comma_cnt_nx;
  logic        valid_nx, active_nx;
  logic        boundary, take, hold_off;

`ifdef PERIODIC_COMMA_EN
  logic [7:0] run_cnt, run_cnt_nx;

  assign hold_off = (run_cnt == 8'(SKIP_PERIOD));

  always_comb begin
    run_cnt_nx = run_cnt;
    if (boundary)
      run_cnt_nx = take ? run_cnt + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) run_cnt <= 8'd0;
    else       run_cnt <= run_cnt_nx;
  end
`else
  // no run limit in this build; legal SKIP_PERIOD is never 0
  assign hold_off = (SKIP_PERIOD == 0);
`endif

  assign boundary  = (bit_cnt == 3'd7);
  assign ready_out = boundary && !hold_off &&
                     (state == SEND || comma_cnt == LAST_COMMA);
  assign take      = valid_in && ready_out;
  assign data_out  = shreg[7];

  always_comb begin
    state_nx     = state;
    shreg_nx     = {shreg[6:0], 1'b0};
    comma_cnt_nx = comma_cnt;
    valid_nx     = valid_out;
    active_nx    = active_out;
    if (boundary) begin
      shreg_nx = take ? data_in : COMMA;
      valid_nx = take;
      case (state)
        SYNC: begin
          comma_cnt_nx = comma_cnt + 4'd1;
          if (comma_cnt == LAST_COMMA) begin
            state_nx  = SEND;
            active_nx = 1'b1;
          end
        end
        SEND: state_nx = SEND;
        default: state_nx = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      shreg      <= COMMA;
      bit_cnt    <= 3'd0;
      comma_cnt  <= 4'd0;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt + 3'd1;
      comma_cnt  <= comma_cnt_nx;
      valid_out  <= valid_nx;
      active_out <= active_nx;
    end
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial: startup commas, handshake,
// back-to-back streaming and mid-byte reset.
module tb_paralelo_serial;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       valid_out;
  logic       active_out;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic lb [0:127];
  logic lv [0:127];
  logic lr [0:127];
  logic la [0:127];
  logic [7:0] src_q [$];

  paralelo_serial dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active_out (active_out)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sample at the negedge, then let one rising edge pass
  task automatic tick();
    logic acc;
    lb[cyc] = data_out;
    lv[cyc] = valid_out;
    lr[cyc] = ready_out;
    la[cyc] = active_out;
    acc = valid_in && ready_out;
    cyc++;
    @(negedge clk_32f);
    if (acc && src_q.size() != 0) void'(src_q.pop_front());
    valid_in = (src_q.size() != 0);
    data_in  = valid_in ? src_q[0] : 8'h00;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_reset(input string tag, input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk(tag, {28'd0, data_out, valid_out, active_out, ready_out},
          32'b1000);
      @(negedge clk_32f);
    end
    reset = 1'b0;
    cyc   = 0;
  endtask

  function automatic logic [7:0] byte_at(input int c);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = lb[c+i];
    return b;
  endfunction

  function automatic int vcount(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(lv[i]);
    return n;
  endfunction

  function automatic int rcount(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(lr[i]);
    return n;
  endfunction

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk_32f);
    hold_reset("por", 2);
    run(12);

    // reset in the middle of the comma run
    hold_reset("rst_mid", 3);

    // idle startup: four commas, then idle commas
    run(40);
    for (int k = 0; k < 5; k++)
      chk($sformatf("idle_byte%0d", k), 32'(byte_at(8*k)), 32'hBC);
    chk("idle_valid", vcount(0, 39), 0);
    chk("idle_rdy_early", rcount(0, 30), 0);
    chk("idle_rdy31", 32'(lr[31]), 1);
    chk("idle_rdy_mid", rcount(32, 38), 0);
    chk("idle_rdy39", 32'(lr[39]), 1);
    chk("idle_act31", 32'(la[31]), 0);
    chk("idle_act32", 32'(la[32]), 1);

    // byte offered from release, accepted at the last comma boundary
    hold_reset("rst_a5", 2);
    src_q.push_back(8'hA5);
    valid_in = 1'b1;
    data_in  = 8'hA5;
    run(48);
    chk("a5_rdy_early", rcount(0, 30), 0);
    chk("a5_rdy31", 32'(lr[31]), 1);
    chk("a5_comma3", 32'(byte_at(24)), 32'hBC);
    chk("a5_comma_valid", vcount(0, 31), 0);
    chk("a5_byte", 32'(byte_at(32)), 32'hA5);
    chk("a5_valid", vcount(32, 39), 8);
    chk("a5_idle", 32'(byte_at(40)), 32'hBC);
    chk("a5_idle_valid", vcount(40, 47), 0);

    // back-to-back stream, including a data byte equal to the comma
    src_q.push_back(8'h00);
    src_q.push_back(8'hFF);
    src_q.push_back(8'hBC);
    valid_in = 1'b1;
    data_in  = 8'h00;
    run(40);
    chk("st_lead", 32'(byte_at(48)), 32'hBC);
    chk("st_lead_valid", vcount(48, 55), 0);
    chk("st_b0", 32'(byte_at(56)), 32'h00);
    chk("st_b1", 32'(byte_at(64)), 32'hFF);
    chk("st_b2", 32'(byte_at(72)), 32'hBC);
    chk("st_valid", vcount(56, 79), 24);
    chk("st_tail", 32'(byte_at(80)), 32'hBC);
    chk("st_tail_valid", vcount(80, 87), 0);
    chk("st_rdy_cnt", rcount(48, 87), 5);
    chk("st_rdy_pos", {29'd0, lr[63], lr[71], lr[79]}, 32'b111);

    // reset at bit 3 of data byte 0xA0
    src_q.push_back(8'hA0);
    valid_in = 1'b1;
    data_in  = 8'hA0;
    run(11);
    chk("mid_bits", {29'd0, lb[96], lb[97], lb[98]}, 32'b101);
    chk("mid_pre", {30'd0, data_out, valid_out}, 32'b01);
    src_q.push_back(8'hC3);
    valid_in = 1'b1;
    data_in  = 8'hC3;
    hold_reset("rst_mid_byte", 2);
    run(48);
    chk("rr_rdy_early", rcount(0, 30), 0);
    chk("rr_act31", 32'(la[31]), 0);
    chk("rr_comma3", 32'(byte_at(24)), 32'hBC);
    chk("rr_comma_valid", vcount(0, 31), 0);
    chk("rr_byte", 32'(byte_at(32)), 32'hC3);
    chk("rr_valid", vcount(32, 39), 8);
    chk("rr_idle", 32'(byte_at(40)), 32'hBC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
